mac_array_seq: RTL and testbench
================================

# mac_array_seq

Sequencer for the 2-D MAC array built from stacked `mac_row`s. On a `start` pulse it reads kernel words, then activation words, from the L0/SRAM interface. It drives the 2-bit instruction (bit1 execute, bit0 kernel load) into each row with a one-cycle-per-row skew, and counts `valid` pulses from the south edge to detect drain completion. It sits between the top-level core FSM and the array/memory datapath.

## Interface
Parameters:
- `row`, 8, number of `mac_row`s in the array
- `addr_bw`, 11, memory address width
- `len_bw`, 8, width of the length fields

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request pulse; sampled only in IDLE
- `kload_len`  in  len_bw  number of kernel words to load; latched at start
- `exec_len`  in  len_bw  number of activation vectors to stream; latched at start
- `wbase`  in  addr_bw  first kernel address; latched at start
- `xbase`  in  addr_bw  first activation address; latched at start
- `ofifo_full`  in  1  output FIFO full; stalls EXEC issue
- `valid_in`  in  1  valid of the last column of the last row
- `mem_ren`  out  1  memory read enable; read data arrives on the next cycle
- `mem_addr`  out  addr_bw  memory read address
- `mem_sel`  out  1  0 = kernel region, 1 = activation region
- `inst_rows`  out  2*row  per-row instruction; bits [2r+1:2r] feed row r
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- **States:** IDLE, KLOAD, GAP, EXEC, DRAIN, DONE.
- **IDLE:**
  - `start`=1 latches the lengths and bases.
  - Goes to KLOAD; goes to GAP if `kload_len`=0.
- **KLOAD:**
  - `mem_ren`=1, `mem_sel`=0, `mem_addr`=wbase+k for k=0..kload_len-1.
  - Goes to GAP after the last word. `ofifo_full` is ignored.
- **GAP:**
  - Exactly one cycle, `mem_ren`=0.
  - Goes to EXEC; goes to DONE if `exec_len`=0.
- **EXEC:**
  - When `ofifo_full`=0: `mem_ren`=1, `mem_sel`=1, `mem_addr`=xbase+k, k advances.
  - When `ofifo_full`=1: `mem_ren`=0 and k holds. This inserts a bubble; no data is dropped.
  - Goes to DRAIN after exec_len issues.
- **Valid counter:**
  - Counts `valid_in` pulses in EXEC and DRAIN. It is cleared in IDLE.
  - DRAIN goes to DONE in the cycle after the count reaches exec_len.
  - If the count reaches exec_len while still in EXEC, DRAIN lasts one cycle.
- **DONE:** one cycle with `done`=1, then IDLE.
- **Instruction generation:**
  - A base instruction register is loaded with {EXEC-issue, KLOAD-issue} one cycle after each issue, to align with memory read latency.
  - `inst_rows[1:0]` = base register.
  - Row r = base register delayed r further cycles through a shift chain.
  - The chain runs in every state, so bubbles and trailing instructions propagate normally.
- **Address arithmetic:** modulo 2^addr_bw; wrap-around is silent.
- **`start` while busy:** ignored, with no effect on latched values.
- **Reset (any time, including mid-operation):**
  - State returns to IDLE.
  - Counters, shift chain and all outputs clear to 0: `mem_ren`, `mem_addr`, `mem_sel`, `inst_rows`, `busy`, `done`.

## Timing
- Cycle 0 is the edge at which `start` is sampled.
- **KLOAD:** cycles 1..L, where L = kload_len.
  - Row 0 sees inst=01 on cycles 2..L+1.
  - Row r sees inst=01 on cycles 2+r..L+1+r.
- **GAP:** cycle L+1.
- **EXEC, no stall:** cycles L+2..L+1+E, where E = exec_len.
  - Row 0 sees inst=10 on cycles L+3..L+2+E.
  - Each stall cycle shifts all later issues by one cycle.
- **`busy`:** rises at cycle 1 and falls at the edge after DONE.
- **`done`:** exactly one cycle wide.

## Test plan
- **Basic run:** row=8, start with wbase=0x010, kload_len=8, xbase=0x100, exec_len=4.
  - `mem_addr` 0x010..0x017 on cycles 1-8 with `mem_sel`=0.
  - 0x100..0x103 on cycles 10-13.
  - `inst_rows[1:0]`=01 on cycles 2-9; `inst_rows[15:14]`=01 on cycles 9-16.
  - Bench pulses `valid_in` 4 times → `done` one cycle later.
- **Stall:** same run with `ofifo_full`=1 on cycles 11-12.
  - Addresses 0x100, then 0x101 on cycle 13.
  - Row 0 inst=00 on cycles 12-13; the final issue at cycle 15.
- **Zero lengths:**
  - exec_len=0 → GAP then DONE, no EXEC reads; `done` at cycle L+2.
  - kload_len=0 → GAP at cycle 1.
- **Wrap and busy start:**
  - xbase=0x7FE, exec_len=4 → addresses 0x7FE, 0x7FF, 0x000, 0x001.
  - A second `start` during EXEC is ignored.
- **Reset mid-EXEC:** assert `reset`=0 asynchronously mid-cycle.
  - All outputs are 0 immediately.
  - After release, a new start runs correctly from IDLE.

Source files
------------

// File: rtl/mac_array_seq.sv
// mac_array_seq: sequences kernel load and activation streaming for the
// stacked mac_row array, skews the per-row instruction by one cycle per row
// and counts south-edge valids to detect drain completion.
module mac_array_seq #(
  parameter int unsigned row     = 8,
  parameter int unsigned addr_bw = 11,
  parameter int unsigned len_bw  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [len_bw-1:0]    kload_len,
  input  logic [len_bw-1:0]    exec_len,
  input  logic [addr_bw-1:0]   wbase,
  input  logic [addr_bw-1:0]   xbase,
  input  logic                 ofifo_full,
  input  logic                 valid_in,
  output logic                 mem_ren,
  output logic [addr_bw-1:0]   mem_addr,
  output logic                 mem_sel,
  output logic [2*row-1:0]     inst_rows,
  output logic                 busy,
  output logic                 done
);

  // One extra bit so "count + 1" and "valid count" never wrap against a length.
  localparam int unsigned CNT_W = len_bw + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_KLOAD, S_GAP, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t             r_state;
  logic [len_bw-1:0]  r_klen;
  logic [len_bw-1:0]  r_elen;
  logic [addr_bw-1:0] r_xbase;
  logic [addr_bw-1:0] r_addr;
  logic [len_bw-1:0]  r_k;
  logic [CNT_W-1:0]   r_vcnt;
  logic               r_busy;
  logic               r_done;
  logic [1:0]         r_inst [row];

  logic               w_kload_issue;
  logic               w_exec_issue;
  logic [CNT_W-1:0]   w_k_next;
  logic               w_last_k;
  logic               w_last_x;
  logic [CNT_W-1:0]   w_vcnt_sum;
  logic               w_drained;
  logic               w_vcnt_inc;

  // EXEC issue reacts to ofifo_full in the same cycle so a full FIFO never
  // receives a read it cannot absorb.
  assign w_kload_issue = (r_state == S_KLOAD);
  assign w_exec_issue  = (r_state == S_EXEC) && !ofifo_full;
  assign w_k_next      = CNT_W'(r_k) + CNT_W'(1);
  assign w_last_k      = (w_k_next == CNT_W'(r_klen));
  assign w_last_x      = (w_k_next == CNT_W'(r_elen));
  assign w_vcnt_sum    = r_vcnt + CNT_W'(valid_in);
  assign w_drained     = (w_vcnt_sum >= CNT_W'(r_elen));
  assign w_vcnt_inc    = valid_in && (r_vcnt < CNT_W'(r_elen));

  assign mem_ren  = w_kload_issue | w_exec_issue;
  assign mem_sel  = (r_state == S_EXEC);
  assign mem_addr = r_addr;
  assign busy     = r_busy;
  assign done     = r_done;

  // Main sequencer: phase control, address/issue counters, valid counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_klen  <= '0;
      r_elen  <= '0;
      r_xbase <= '0;
      r_addr  <= '0;
      r_k     <= '0;
      r_vcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_vcnt <= '0;
          if (start) begin
            r_klen  <= kload_len;
            r_elen  <= exec_len;
            r_xbase <= xbase;
            r_addr  <= wbase;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= (kload_len == '0) ? S_GAP : S_KLOAD;
          end
        end
        S_KLOAD: begin
          r_addr <= r_addr + addr_bw'(1);
          r_k    <= r_k + len_bw'(1);
          if (w_last_k) r_state <= S_GAP;
        end
        S_GAP: begin
          r_addr <= r_xbase;
          r_k    <= '0;
          if (r_elen == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_vcnt_inc) r_vcnt <= w_vcnt_sum;
          if (w_exec_issue) begin
            r_addr <= r_addr + addr_bw'(1);
            r_k    <= r_k + len_bw'(1);
            if (w_last_x) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_vcnt_inc) r_vcnt <= w_vcnt_sum;
          if (w_drained) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Instruction skew chain: base register lags the issue by one cycle to
  // match read latency, each further row lags one more cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(row); i++) r_inst[i] <= 2'b00;
    end else begin
      r_inst[0] <= {w_exec_issue, w_kload_issue};
      for (int i = 1; i < int'(row); i++) r_inst[i] <= r_inst[i-1];
    end
  end

  // Flatten the chain onto the per-row instruction bus.
  always_comb begin
    inst_rows = '0;
    for (int i = 0; i < int'(row); i++) inst_rows[2*i +: 2] = r_inst[i];
  end

endmodule

// File: tb/tb_mac_array_seq.sv
// Directed bench for mac_array_seq: kernel/exec address streams, stalls,
// zero lengths, address wrap, start-while-busy and mid-run async reset.
module tb_mac_array_seq;

  localparam int ROW = 8;
  localparam int NC  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        kload_len;
  logic [7:0]        exec_len;
  logic [10:0]       wbase;
  logic [10:0]       xbase;
  logic              ofifo_full;
  logic              valid_in;
  logic              mem_ren;
  logic [10:0]       mem_addr;
  logic              mem_sel;
  logic [2*ROW-1:0]  inst_rows;
  logic              busy;
  logic              done;

  int n_vec  = 0;
  int n_miss = 0;

  mac_array_seq #(.row(ROW), .addr_bw(11), .len_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .kload_len(kload_len), .exec_len(exec_len),
    .wbase(wbase), .xbase(xbase),
    .ofifo_full(ofifo_full), .valid_in(valid_in),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .inst_rows(inst_rows), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ren"},  32'(mem_ren),   32'd0);
    chk({tag, " addr"}, 32'(mem_addr),  32'd0);
    chk({tag, " sel"},  32'(mem_sel),   32'd0);
    chk({tag, " inst"}, 32'(inst_rows), 32'd0);
    chk({tag, " busy"}, 32'(busy),      32'd0);
    chk({tag, " done"}, 32'(done),      32'd0);
  endtask

  // One complete run. Cycle c is observed just after the falling edge that
  // precedes the c-th rising edge after start; cycle 0 is where start is held.
  // Stalls cover cycles s_lo..s_hi (s_lo=0: none). valid_in pulses on E
  // consecutive cycles from vfirst. restart_c re-pulses start with other
  // values; abort_c drops reset mid-cycle and ends the run there.
  task automatic run(input int L, input int E, input int wb, input int xb,
                     input int s_lo, input int s_hi, input int vfirst,
                     input int restart_c, input int abort_c);
    bit kiss [NC];
    bit xiss [NC];
    int eaddr [NC];
    int last_issue, t_done, v_last, n, c, ncyc;
    logic [15:0] exp_inst;
    for (int i = 0; i < NC; i++) begin
      kiss[i] = 1'b0; xiss[i] = 1'b0; eaddr[i] = 0;
    end
    for (int k = 0; k < L; k++) begin
      kiss[1+k]  = 1'b1;
      eaddr[1+k] = (wb + k) & 'h7FF;
    end
    n = 0;
    c = L + 2;
    last_issue = L + 1;
    while (n < E) begin
      if (!(s_lo > 0 && c >= s_lo && c <= s_hi)) begin
        xiss[c]  = 1'b1;
        eaddr[c] = (xb + n) & 'h7FF;
        last_issue = c;
        n++;
      end
      c++;
    end
    v_last = vfirst + E - 1;
    if (E == 0) t_done = L + 2;
    else        t_done = (v_last + 1 > last_issue + 2) ? v_last + 1 : last_issue + 2;
    ncyc = t_done + ROW + 2;

    for (int cy = 0; cy <= ncyc; cy++) begin
      @(negedge clk);
      start      = (cy == 0) || (cy == restart_c);
      kload_len  = (cy == restart_c) ? 8'h55 : 8'(L);
      exec_len   = (cy == restart_c) ? 8'h33 : 8'(E);
      wbase      = (cy == restart_c) ? 11'h3A0 : 11'(wb);
      xbase      = (cy == restart_c) ? 11'h0C0 : 11'(xb);
      ofifo_full = (s_lo > 0 && cy >= s_lo && cy <= s_hi);
      valid_in   = (E > 0 && cy >= vfirst && cy <= v_last);
      #1;
      chk($sformatf("L%0d E%0d c%0d ren", L, E, cy), 32'(mem_ren), 32'(kiss[cy] | xiss[cy]));
      if (kiss[cy] | xiss[cy]) begin
        chk($sformatf("L%0d E%0d c%0d addr", L, E, cy), 32'(mem_addr), 32'(eaddr[cy]));
        chk($sformatf("L%0d E%0d c%0d sel", L, E, cy), 32'(mem_sel), 32'(xiss[cy]));
      end
      exp_inst = '0;
      for (int r = 0; r < ROW; r++) begin
        if (cy - 1 - r >= 0) exp_inst[2*r +: 2] = {xiss[cy-1-r], kiss[cy-1-r]};
      end
      chk($sformatf("L%0d E%0d c%0d inst", L, E, cy), 32'(inst_rows), 32'(exp_inst));
      chk($sformatf("L%0d E%0d c%0d busy", L, E, cy), 32'(busy), 32'(cy >= 1 && cy <= t_done));
      chk($sformatf("L%0d E%0d c%0d done", L, E, cy), 32'(done), 32'(cy == t_done));
      if (cy == abort_c) begin
        start = 1'b0; ofifo_full = 1'b0; valid_in = 1'b0;
        #2 reset = 1'b0;
        #1 chk_all_zero($sformatf("abort c%0d", cy));
        @(negedge clk);
        chk_all_zero("held reset");
        reset = 1'b1;
        break;
      end
    end
    start = 1'b0; ofifo_full = 1'b0; valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; kload_len = '0; exec_len = '0;
    wbase = '0; xbase = '0; ofifo_full = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    #1 chk_all_zero("in reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 chk_all_zero("after reset");

    // Basic: kernel 0x010..0x017 at 1-8, acts 0x100..0x103 at 10-13, done 18.
    run(8, 4, 'h010, 'h100, 0, 0, 14, -1, -1);
    // Stall on cycles 11-12: 0x101 moves to 13, last issue 15, done 20.
    run(8, 4, 'h010, 'h100, 11, 12, 16, -1, -1);
    // exec_len = 0: GAP at 4, done at 5, no activation reads.
    run(3, 0, 'h030, 'h040, 0, 0, 0, -1, -1);
    // kload_len = 0: GAP at 1, EXEC 2-3, done 6.
    run(0, 2, 'h050, 'h020, 0, 0, 4, -1, -1);
    // Wrap 0x7FE..0x001, valids during EXEC (one-cycle DRAIN), start while busy.
    run(2, 4, 'h005, 'h7FE, 0, 0, 4, 6, -1);
    // Async reset in the middle of EXEC, then a fresh run from IDLE.
    run(2, 4, 'h000, 'h200, 0, 0, 8, -1, 6);
    run(1, 3, 'h011, 'h022, 0, 0, 6, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
